// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage and the register file.
// Source encoding, default word/address sizes and the queued entry layout.
package wb_pkg;

    localparam int WB_WORD_SIZE  = 16;
    localparam int WB_ADDR_SIZE  = 3;
    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADDR_SIZE-1:0] addr;
        logic [WB_WORD_SIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO holding {addr, data} register writes.
// With WB_PENDING_QUERY_EN defined, every slot's address and an occupancy
// mask are exported so the parent can match in-flight destinations.
module wb_fifo #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_pushAddr,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_headAddr,
    output logic [DATA_W-1:0] o_headData
`ifdef WB_PENDING_QUERY_EN
    ,
    output logic [DEPTH-1:0]        o_occValid,
    output logic [DEPTH*ADDR_W-1:0] o_occAddr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addrMem [DEPTH];
    logic [DATA_W-1:0] r_dataMem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_doPush   = i_push && !o_full;
    assign w_doPop    = i_pop && !o_empty;
    assign o_headAddr = r_addrMem[r_rdPtr];
    assign o_headData = r_dataMem[r_rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // is unchanged when a push and a pop land in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
            else if (!w_doPush && w_doPop) r_count <= r_count - 1'b1;
        end
    end

    // Slot storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_addrMem[r_wrPtr] <= i_pushAddr;
            r_dataMem[r_wrPtr] <= i_pushData;
        end
    end

`ifdef WB_PENDING_QUERY_EN
    // A slot is occupied when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [PTR_W-1:0] w_offset;
        assign w_offset = PTR_W'(gi) - r_rdPtr;
        assign o_occValid[gi] = ({1'b0, w_offset} < r_count);
        assign o_occAddr[gi*ADDR_W +: ADDR_W] = r_addrMem[gi];
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage feeding the register file's single write port.
// ALU and load results queue in per-source FIFOs; a round-robin arbiter
// drains one entry per cycle into the registered wrt* port.
// Optional: define WB_PENDING_QUERY_EN to add qryAddr/qryPending, which flag
// any queued or presented write targeting qryAddr.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int WORD_SIZE  = WB_WORD_SIZE,
    parameter int ADDR_SIZE  = WB_ADDR_SIZE,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aluValid,
    output logic                 aluReady,
    input  logic [ADDR_SIZE-1:0] aluAddr,
    input  logic [WORD_SIZE-1:0] aluData,
    input  logic                 memValid,
    output logic                 memReady,
    input  logic [ADDR_SIZE-1:0] memAddr,
    input  logic [WORD_SIZE-1:0] memData,
    output logic                 wrtEnable,
    output logic [ADDR_SIZE-1:0] wrtAddr,
    output logic [WORD_SIZE-1:0] wrtData,
    output logic                 idle
`ifdef WB_PENDING_QUERY_EN
    ,
    input  logic [ADDR_SIZE-1:0] qryAddr,
    output logic                 qryPending
`endif
);

    logic                 w_aluFull,  w_aluEmpty, w_aluPop;
    logic                 w_memFull,  w_memEmpty, w_memPop;
    logic [ADDR_SIZE-1:0] w_aluHeadAddr, w_memHeadAddr;
    logic [WORD_SIZE-1:0] w_aluHeadData, w_memHeadData;
    logic                 w_grantValid;
    wb_src_e              w_grantSrc;
    wb_src_e              r_lastGrant;

    // Ready is purely a function of occupancy and reset, never of valid.
    assign aluReady = !w_aluFull && !rst;
    assign memReady = !w_memFull && !rst;
    assign w_aluPop = w_grantValid && (w_grantSrc == SRC_ALU);
    assign w_memPop = w_grantValid && (w_grantSrc == SRC_MEM);
    assign idle     = w_aluEmpty && w_memEmpty && !wrtEnable;

`ifdef WB_PENDING_QUERY_EN
    logic [FIFO_DEPTH-1:0]           w_aluOccValid, w_memOccValid;
    logic [FIFO_DEPTH*ADDR_SIZE-1:0] w_aluOccAddr,  w_memOccAddr;
`endif

    wb_fifo #(.ADDR_W(ADDR_SIZE), .DATA_W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_aluFifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (aluValid && aluReady),
        .i_pushAddr (aluAddr),
        .i_pushData (aluData),
        .i_pop      (w_aluPop),
        .o_full     (w_aluFull),
        .o_empty    (w_aluEmpty),
        .o_headAddr (w_aluHeadAddr),
        .o_headData (w_aluHeadData)
`ifdef WB_PENDING_QUERY_EN
        ,
        .o_occValid (w_aluOccValid),
        .o_occAddr  (w_aluOccAddr)
`endif
    );

    wb_fifo #(.ADDR_W(ADDR_SIZE), .DATA_W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_memFifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (memValid && memReady),
        .i_pushAddr (memAddr),
        .i_pushData (memData),
        .i_pop      (w_memPop),
        .o_full     (w_memFull),
        .o_empty    (w_memEmpty),
        .o_headAddr (w_memHeadAddr),
        .o_headData (w_memHeadData)
`ifdef WB_PENDING_QUERY_EN
        ,
        .o_occValid (w_memOccValid),
        .o_occAddr  (w_memOccAddr)
`endif
    );

    // Round-robin pick: a lone non-empty source wins, otherwise alternate away from lastGrant.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantSrc   = SRC_ALU;
        if (!w_aluEmpty && !w_memEmpty) begin
            w_grantValid = 1'b1;
            w_grantSrc   = (r_lastGrant == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end else if (!w_aluEmpty) begin
            w_grantValid = 1'b1;
            w_grantSrc   = SRC_ALU;
        end else if (!w_memEmpty) begin
            w_grantValid = 1'b1;
            w_grantSrc   = SRC_MEM;
        end
    end

    // Registered write port; address/data hold their value whenever nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrtEnable   <= 1'b0;
            wrtAddr     <= '0;
            wrtData     <= '0;
            r_lastGrant <= SRC_MEM;
        end else begin
            wrtEnable <= w_grantValid;
            if (w_grantValid) begin
                wrtAddr     <= (w_grantSrc == SRC_MEM) ? w_memHeadAddr : w_aluHeadAddr;
                wrtData     <= (w_grantSrc == SRC_MEM) ? w_memHeadData : w_aluHeadData;
                r_lastGrant <= w_grantSrc;
            end
        end
    end

`ifdef WB_PENDING_QUERY_EN
    logic w_qryHit;

    // Flag any occupied slot of either source, or the live write, that targets qryAddr.
    always_comb begin
        w_qryHit = wrtEnable && (wrtAddr == qryAddr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_aluOccValid[i] && (w_aluOccAddr[i*ADDR_SIZE +: ADDR_SIZE] == qryAddr))
                w_qryHit = 1'b1;
            if (w_memOccValid[i] && (w_memOccAddr[i*ADDR_SIZE +: ADDR_SIZE] == qryAddr))
                w_qryHit = 1'b1;
        end
    end

    assign qryPending = w_qryHit;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed stimulus for wb_arbiter, checked
// every cycle against a queue-based reference of the writeback rules.
// Covers the qryAddr/qryPending ports when WB_PENDING_QUERY_EN is defined.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int AW    = WB_ADDR_SIZE;
   localparam int DW    = WB_WORD_SIZE;
   localparam int DEPTH = WB_FIFO_DEPTH;

   logic          clk;
   logic          rst;
   logic          aluValid, memValid;
   logic          aluReady, memReady;
   logic [AW-1:0] aluAddr, memAddr;
   logic [DW-1:0] aluData, memData;
   logic          wrtEnable;
   logic [AW-1:0] wrtAddr;
   logic [DW-1:0] wrtData;
   logic          idle;
`ifdef WB_PENDING_QUERY_EN
   logic [AW-1:0] qryAddr;
   logic          qryPending;
`endif

   int testsRun;
   int testsFailed;

   // Reference state: per-source queues, the presented write and the register file contents.
   wb_entry_t     aluQ[$];
   wb_entry_t     memQ[$];
   bit            mWrtEn;
   logic [AW-1:0] mWrtAddr;
   logic [DW-1:0] mWrtData;
   bit            mLastMem;
   logic [DW-1:0] modelRegs [8];
   logic [DW-1:0] dutRegs   [8];

   wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .aluValid  (aluValid),
      .aluReady  (aluReady),
      .aluAddr   (aluAddr),
      .aluData   (aluData),
      .memValid  (memValid),
      .memReady  (memReady),
      .memAddr   (memAddr),
      .memData   (memData),
      .wrtEnable (wrtEnable),
      .wrtAddr   (wrtAddr),
      .wrtData   (wrtData),
      .idle      (idle)
`ifdef WB_PENDING_QUERY_EN
      ,
      .qryAddr   (qryAddr),
      .qryPending(qryPending)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: observed 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge, then advance the reference.
   task automatic applyStimulus(input bit r,
                                input bit aV, input logic [AW-1:0] aA, input logic [DW-1:0] aD,
                                input bit mV, input logic [AW-1:0] mA, input logic [DW-1:0] mD,
                                input logic [AW-1:0] qA);
      bit        expAluRdy, expMemRdy, expIdle, expPend;
      wb_entry_t e;
      rst      = r;
      aluValid = aV; aluAddr = aA; aluData = aD;
      memValid = mV; memAddr = mA; memData = mD;
`ifdef WB_PENDING_QUERY_EN
      qryAddr  = qA;
`endif
      @(negedge clk);
      expAluRdy = (aluQ.size() < DEPTH) && !r;
      expMemRdy = (memQ.size() < DEPTH) && !r;
      expIdle   = (aluQ.size() == 0) && (memQ.size() == 0) && !mWrtEn;
      checkOutput("aluReady",  32'(aluReady),  32'(expAluRdy));
      checkOutput("memReady",  32'(memReady),  32'(expMemRdy));
      checkOutput("idle",      32'(idle),      32'(expIdle));
      checkOutput("wrtEnable", 32'(wrtEnable), 32'(mWrtEn));
      checkOutput("wrtAddr",   32'(wrtAddr),   32'(mWrtAddr));
      checkOutput("wrtData",   32'(wrtData),   32'(mWrtData));
      expPend = mWrtEn && (mWrtAddr == qA);
      foreach (aluQ[i]) if (aluQ[i].addr == qA) expPend = 1'b1;
      foreach (memQ[i]) if (memQ[i].addr == qA) expPend = 1'b1;
`ifdef WB_PENDING_QUERY_EN
      checkOutput("qryPending", 32'(qryPending), 32'(expPend));
`endif
      if (wrtEnable === 1'b1) dutRegs[wrtAddr] = wrtData;

      // Register file commits whatever is presented at this edge.
      if (mWrtEn) modelRegs[mWrtAddr] = mWrtData;
      if (r) begin
         aluQ.delete();
         memQ.delete();
         mWrtEn   = 1'b0;
         mWrtAddr = '0;
         mWrtData = '0;
         mLastMem = 1'b1;
      end else begin
         if (aluQ.size() > 0 && (memQ.size() == 0 || mLastMem)) begin
            e = aluQ.pop_front();
            mWrtEn = 1'b1; mWrtAddr = e.addr; mWrtData = e.data; mLastMem = 1'b0;
         end else if (memQ.size() > 0) begin
            e = memQ.pop_front();
            mWrtEn = 1'b1; mWrtAddr = e.addr; mWrtData = e.data; mLastMem = 1'b1;
         end else begin
            mWrtEn = 1'b0;
         end
         if (aV && expAluRdy) aluQ.push_back('{addr: aA, data: aD});
         if (mV && expMemRdy) memQ.push_back('{addr: mA, data: mD});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      mWrtEn = 1'b0; mWrtAddr = '0; mWrtData = '0; mLastMem = 1'b1;
      for (int i = 0; i < 8; i++) begin
         modelRegs[i] = '0;
         dutRegs[i]   = '0;
      end
      rst = 1'b1;
      aluValid = 1'b0; aluAddr = '0; aluData = '0;
      memValid = 1'b0; memAddr = '0; memData = '0;
`ifdef WB_PENDING_QUERY_EN
      qryAddr = '0;
`endif
      repeat (2) @(posedge clk);
      #1;

      // Reset held: readies low, port cleared.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

      // Single uncontested ALU write, then drain back to idle.
      applyStimulus(0, 1, 3'd3, 16'h1234, 0, 0, 0, 3'd3);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd3);

      // Both sources saturated: alternation and back-pressure.
      for (int i = 0; i < 12; i++)
         applyStimulus(0, 1, AW'(1 + i % 4), DW'(16'hA000 + i), 1, AW'(5 + i % 4), DW'(16'hB000 + i), AW'(i));

      // Reset with both FIFOs full and a write presented, then nothing stale follows.
      applyStimulus(1, 1, 3'd1, 16'hDEAD, 1, 3'd5, 16'hBEEF, 3'd1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd5);

      // Same destination from both sources in one cycle: ALU first, MEM wins.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 3'd2, 16'hAAAA, 1, 3'd2, 16'hBBBB, 3'd2);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd2);
      checkOutput("reg2LastWins", 32'(dutRegs[2]), 32'h0000_BBBB);

      // MEM-only stream with pending queries on address 6.
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 3'd6, DW'(16'hC000 + i), 3'd6);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, (i % 2 == 0) ? 3'd6 : 3'd7);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 9) < 6), AW'($urandom), DW'($urandom),
                       ($urandom_range(0, 9) < 6), AW'($urandom), DW'($urandom),
                       AW'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Final register file image must match commit order.
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("reg%0d", i), 32'(dutRegs[i]), 32'(modelRegs[i]));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
